// File: rtl/imm_pkg.sv
// Shared definitions for the immediate-generation stage: format codes, FSM
// states, RISC-V major opcodes and the classify/extend helpers.
package imm_pkg;

   typedef enum logic [2:0] {
      FMT_I    = 3'd0,
      FMT_S    = 3'd1,
      FMT_B    = 3'd2,
      FMT_U    = 3'd3,
      FMT_J    = 3'd4,
      FMT_R    = 3'd5,
      FMT_NONE = 3'd7
   } fmt_e;

   typedef enum logic [1:0] {
      ST_EMPTY = 2'd0,
      ST_ONE   = 2'd1,
      ST_TWO   = 2'd2
   } state_e;

   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_IMM    = 7'b0010011;
   localparam logic [6:0] OP_JALR   = 7'b1100111;
   localparam logic [6:0] OP_SYSTEM = 7'b1110011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_AUIPC  = 7'b0010111;
   localparam logic [6:0] OP_LUI    = 7'b0110111;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_OP     = 7'b0110011;
   localparam logic [6:0] OP_IMM32  = 7'b0011011;
   localparam logic [6:0] OP_OP32   = 7'b0111011;

   function automatic fmt_e classify(input logic [31:0] instr, input logic rv64);
      fmt_e f;
      f = FMT_NONE;
      case (instr[6:0])
         OP_LOAD, OP_IMM, OP_JALR, OP_SYSTEM: f = FMT_I;
         OP_STORE:                            f = FMT_S;
         OP_BRANCH:                           f = FMT_B;
         OP_AUIPC, OP_LUI:                    f = FMT_U;
         OP_JAL:                              f = FMT_J;
         OP_OP:                               f = FMT_R;
         OP_IMM32:                            f = rv64 ? FMT_I : FMT_NONE;
         OP_OP32:                             f = rv64 ? FMT_R : FMT_NONE;
         default:                             f = FMT_NONE;
      endcase
      return f;
   endfunction

   // Every format takes its sign from instr[31], so a 32-bit result widened
   // by replicating bit 31 is correct for any XLEN.
   function automatic logic [31:0] extend(input logic [31:0] instr, input fmt_e fmt);
      logic [31:0] imm;
      imm = 32'b0;
      case (fmt)
         FMT_I: imm = {{20{instr[31]}}, instr[31:20]};
         FMT_S: imm = {{20{instr[31]}}, instr[31:25], instr[11:7]};
         FMT_B: imm = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
         FMT_J: imm = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
         FMT_U: imm = {instr[31:12], 12'b0};
         default: imm = 32'b0;
      endcase
      return imm;
   endfunction

endpackage

// File: rtl/imm_extend.sv
// Combinational classifier and immediate extender for one instruction word.
module imm_extend
   import imm_pkg::*;
#(
   parameter int XLEN = 32
) (
   input  logic [31:0]     instr,
   output logic [XLEN-1:0] imm,
   output logic [2:0]      fmt,
   output logic            illegal
);

   fmt_e        fmt_c;
   logic [31:0] imm32;

   assign fmt_c   = classify(instr, XLEN == 64);
   assign imm32   = extend(instr, fmt_c);
   assign fmt     = fmt_c;
   assign illegal = (fmt_c == FMT_NONE);

   generate
      if (XLEN == 64) begin : g_rv64
         assign imm = {{32{imm32[31]}}, imm32};
      end else begin : g_rv32
         assign imm = imm32;
      end
   endgenerate

endmodule

// File: rtl/imm_decode_stage.sv
// Registered immediate-generation stage: valid/ready pipeline register with an
// optional skid entry, flush, and a saturating illegal-opcode counter.
module imm_decode_stage
   import imm_pkg::*;
#(
   parameter int XLEN  = 32,
   parameter bit SKID  = 1,
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             flush,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [31:0]      in_instr,
   input  logic [XLEN-1:0]  in_pc,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [31:0]      out_instr,
   output logic [XLEN-1:0]  out_pc,
   output logic [XLEN-1:0]  out_imm,
   output logic [2:0]       out_fmt,
   output logic             out_illegal,
   output logic [CNT_W-1:0] illegal_cnt
);

   state_e            state_reg, state_next;
   logic [XLEN-1:0]   ext_imm;
   logic [2:0]        ext_fmt;
   logic              ext_illegal;
   logic [31:0]       main_instr_reg, skid_instr_reg;
   logic [XLEN-1:0]   main_pc_reg, skid_pc_reg;
   logic [XLEN-1:0]   main_imm_reg, skid_imm_reg;
   logic [2:0]        main_fmt_reg, skid_fmt_reg;
   logic              main_ill_reg, skid_ill_reg;
   logic [CNT_W-1:0]  cnt_reg;
   logic              accept, drain, load_main, load_skid, promote;

   imm_extend #(.XLEN(XLEN)) u_extend (
      .instr   (in_instr),
      .imm     (ext_imm),
      .fmt     (ext_fmt),
      .illegal (ext_illegal)
   );

   assign accept    = in_valid && in_ready;
   assign out_valid = (state_reg != ST_EMPTY);
   assign drain     = out_valid && out_ready;

   always_comb begin
      state_next = state_reg;
      load_main  = 1'b0;
      load_skid  = 1'b0;
      promote    = 1'b0;
      if (flush) begin
         state_next = ST_EMPTY;
      end else begin
         case (state_reg)
            ST_EMPTY: if (accept) begin
               state_next = ST_ONE;
               load_main  = 1'b1;
            end
            ST_ONE: begin
               if (accept && drain) begin
                  load_main = 1'b1;
               end else if (accept) begin
                  state_next = ST_TWO;
                  load_skid  = 1'b1;
               end else if (drain) begin
                  state_next = ST_EMPTY;
               end
            end
            ST_TWO: if (drain) begin
               state_next = ST_ONE;
               promote    = 1'b1;
            end
            default: state_next = ST_EMPTY;
         endcase
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) state_reg <= ST_EMPTY;
      else       state_reg <= state_next;
   end

   // With a skid entry in_ready is a flop; without one it must look through
   // to out_ready so a full register can still take a new entry while draining.
   generate
      if (SKID) begin : g_skid
         logic in_ready_reg;
         always_ff @(posedge clk or posedge reset) begin
            if (reset) in_ready_reg <= 1'b1;
            else       in_ready_reg <= (state_next != ST_TWO);
         end
         assign in_ready = in_ready_reg;
      end else begin : g_single
         assign in_ready = (state_reg == ST_EMPTY) || out_ready;
      end
   endgenerate

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         main_instr_reg <= '0;
         main_pc_reg    <= '0;
         main_imm_reg   <= '0;
         main_fmt_reg   <= 3'd7;
         main_ill_reg   <= 1'b0;
         skid_instr_reg <= '0;
         skid_pc_reg    <= '0;
         skid_imm_reg   <= '0;
         skid_fmt_reg   <= 3'd7;
         skid_ill_reg   <= 1'b0;
      end else begin
         if (load_main) begin
            main_instr_reg <= in_instr;
            main_pc_reg    <= in_pc;
            main_imm_reg   <= ext_imm;
            main_fmt_reg   <= ext_fmt;
            main_ill_reg   <= ext_illegal;
         end else if (promote) begin
            main_instr_reg <= skid_instr_reg;
            main_pc_reg    <= skid_pc_reg;
            main_imm_reg   <= skid_imm_reg;
            main_fmt_reg   <= skid_fmt_reg;
            main_ill_reg   <= skid_ill_reg;
         end
         if (load_skid) begin
            skid_instr_reg <= in_instr;
            skid_pc_reg    <= in_pc;
            skid_imm_reg   <= ext_imm;
            skid_fmt_reg   <= ext_fmt;
            skid_ill_reg   <= ext_illegal;
         end
      end
   end

   // Counts deliveries, so a handshake in a flush cycle still registers.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cnt_reg <= '0;
      end else if (drain && main_ill_reg && (cnt_reg != {CNT_W{1'b1}})) begin
         cnt_reg <= cnt_reg + CNT_W'(1);
      end
   end

   assign out_instr   = main_instr_reg;
   assign out_pc      = main_pc_reg;
   assign out_imm     = main_imm_reg;
   assign out_fmt     = main_fmt_reg;
   assign out_illegal = main_ill_reg;
   assign illegal_cnt = cnt_reg;

endmodule

// File: tb/tb_imm_decode_stage.sv
// Drives an RV32/skid instance and an RV64/single-register instance from one
// stimulus stream and compares both against queue-based reference models.
module tb_imm_decode_stage;

   typedef struct packed {
      logic [31:0] instr;
      logic [63:0] pc;
   } ent_t;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        flush, in_valid, out_ready;
   logic [31:0] in_instr;
   logic [63:0] in_pc;

   logic        in_ready32, out_valid32, out_illegal32;
   logic [31:0] out_instr32, out_pc32, out_imm32;
   logic [2:0]  out_fmt32;
   logic [1:0]  illegal_cnt32;

   logic        in_ready64, out_valid64, out_illegal64;
   logic [31:0] out_instr64;
   logic [63:0] out_pc64, out_imm64;
   logic [2:0]  out_fmt64;
   logic [15:0] illegal_cnt64;

   int n_cmp = 0;
   int n_bad = 0;

   ent_t q32[$];
   ent_t q64[$];
   int   cnt32 = 0;
   int   cnt64 = 0;
   bit   fire32, fire64, acc32, acc64;
   ent_t in_ent;

   logic [6:0] ops [13] = '{7'h03, 7'h13, 7'h67, 7'h73, 7'h23, 7'h63, 7'h17,
                            7'h37, 7'h6F, 7'h33, 7'h1B, 7'h3B, 7'h7F};

   always #5 clk = ~clk;

   imm_decode_stage #(.XLEN(32), .SKID(1'b1), .CNT_W(2)) dut32 (
      .clk(clk), .reset(reset), .flush(flush),
      .in_valid(in_valid), .in_ready(in_ready32), .in_instr(in_instr), .in_pc(in_pc[31:0]),
      .out_valid(out_valid32), .out_ready(out_ready), .out_instr(out_instr32),
      .out_pc(out_pc32), .out_imm(out_imm32), .out_fmt(out_fmt32),
      .out_illegal(out_illegal32), .illegal_cnt(illegal_cnt32)
   );

   imm_decode_stage #(.XLEN(64), .SKID(1'b0), .CNT_W(16)) dut64 (
      .clk(clk), .reset(reset), .flush(flush),
      .in_valid(in_valid), .in_ready(in_ready64), .in_instr(in_instr), .in_pc(in_pc),
      .out_valid(out_valid64), .out_ready(out_ready), .out_instr(out_instr64),
      .out_pc(out_pc64), .out_imm(out_imm64), .out_fmt(out_fmt64),
      .out_illegal(out_illegal64), .illegal_cnt(illegal_cnt64)
   );

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   function automatic int ref_fmt(input logic [31:0] i, input bit w64);
      case (i[6:0])
         7'h03, 7'h13, 7'h67, 7'h73: return 0;
         7'h23:                      return 1;
         7'h63:                      return 2;
         7'h17, 7'h37:               return 3;
         7'h6F:                      return 4;
         7'h33:                      return 5;
         7'h1B:                      return w64 ? 0 : 7;
         7'h3B:                      return w64 ? 5 : 7;
         default:                    return 7;
      endcase
   endfunction

   // Immediate value as a signed integer, built from field weights.
   function automatic longint ref_imm(input logic [31:0] i, input bit w64);
      longint s, sign;
      s    = longint'($signed(i));
      sign = (s < 0) ? -1 : 0;
      case (ref_fmt(i, w64))
         0: return s >>> 20;
         1: return (s >>> 25) * 32 + longint'(i[11:7]);
         2: return sign * 4096 + longint'(i[7]) * 2048 + longint'(i[30:25]) * 32
                   + longint'(i[11:8]) * 2;
         3: return (s >>> 12) * 4096;
         4: return sign * 1048576 + longint'(i[19:12]) * 4096 + longint'(i[20]) * 2048
                   + longint'(i[30:21]) * 2;
         default: return 0;
      endcase
   endfunction

   function automatic logic [31:0] rand_instr();
      logic [31:0] r;
      r      = $urandom;
      r[6:0] = ops[$urandom_range(0, 12)];
      return r;
   endfunction

   // Reference models: a FIFO of depth 2 (skid) or 1 (single register).
   always @(posedge clk or posedge reset) begin
      if (reset) begin
         q32.delete();
         q64.delete();
         cnt32 = 0;
         cnt64 = 0;
      end else begin
         in_ent.instr = in_instr;
         in_ent.pc    = in_pc;
         fire32 = (q32.size() != 0) && out_ready;
         fire64 = (q64.size() != 0) && out_ready;
         acc32  = in_valid && (q32.size() < 2);
         acc64  = in_valid && ((q64.size() == 0) || out_ready);
         if (fire32 && ref_fmt(q32[0].instr, 1'b0) == 7 && cnt32 < 3) cnt32++;
         if (fire64 && ref_fmt(q64[0].instr, 1'b1) == 7 && cnt64 < 65535) cnt64++;
         if (flush) begin
            q32.delete();
            q64.delete();
         end else begin
            if (fire32) void'(q32.pop_front());
            if (fire64) void'(q64.pop_front());
            if (acc32) q32.push_back(in_ent);
            if (acc64) q64.push_back(in_ent);
         end
      end
   end

   task automatic check_all();
      ent_t e;
      check("valid32", 64'(out_valid32), 64'(q32.size() != 0));
      check("inrdy32", 64'(in_ready32), 64'(q32.size() < 2));
      if (q32.size() != 0) begin
         e = q32[0];
         check("instr32", 64'(out_instr32), 64'(e.instr));
         check("pc32", 64'(out_pc32), 64'(e.pc[31:0]));
         check("imm32", 64'(out_imm32), 64'(ref_imm(e.instr, 1'b0)) & 64'hFFFF_FFFF);
         check("fmt32", 64'(out_fmt32), 64'(ref_fmt(e.instr, 1'b0)));
         check("ill32", 64'(out_illegal32), 64'(ref_fmt(e.instr, 1'b0) == 7));
      end
      check("cnt32", 64'(illegal_cnt32), 64'(cnt32));
      check("valid64", 64'(out_valid64), 64'(q64.size() != 0));
      check("inrdy64", 64'(in_ready64), 64'((q64.size() == 0) || out_ready));
      if (q64.size() != 0) begin
         e = q64[0];
         check("instr64", 64'(out_instr64), 64'(e.instr));
         check("pc64", out_pc64, e.pc);
         check("imm64", out_imm64, 64'(ref_imm(e.instr, 1'b1)));
         check("fmt64", 64'(out_fmt64), 64'(ref_fmt(e.instr, 1'b1)));
         check("ill64", 64'(out_illegal64), 64'(ref_fmt(e.instr, 1'b1) == 7));
      end
      check("cnt64", 64'(illegal_cnt64), 64'(cnt64));
   endtask

   task automatic step();
      @(negedge clk);
      check_all();
   endtask

   task automatic check_reset_vals(input string tag);
      check({tag, "_valid32"}, 64'(out_valid32), 64'd0);
      check({tag, "_rdy32"}, 64'(in_ready32), 64'd1);
      check({tag, "_instr32"}, 64'(out_instr32), 64'd0);
      check({tag, "_pc32"}, 64'(out_pc32), 64'd0);
      check({tag, "_imm32"}, 64'(out_imm32), 64'd0);
      check({tag, "_fmt32"}, 64'(out_fmt32), 64'd7);
      check({tag, "_ill32"}, 64'(out_illegal32), 64'd0);
      check({tag, "_cnt32"}, 64'(illegal_cnt32), 64'd0);
      check({tag, "_valid64"}, 64'(out_valid64), 64'd0);
      check({tag, "_fmt64"}, 64'(out_fmt64), 64'd7);
      check({tag, "_imm64"}, out_imm64, 64'd0);
      check({tag, "_cnt64"}, 64'(illegal_cnt64), 64'd0);
   endtask

   task automatic send(input logic [31:0] ins);
      in_valid = 1'b1;
      in_instr = ins;
      in_pc    = {$urandom, $urandom};
      step();
      in_valid = 1'b0;
   endtask

   initial begin
      flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
      in_instr = '0; in_pc = '0;
      step();
      step();
      check_reset_vals("rst");
      reset = 1'b0;
      out_ready = 1'b1;

      // Directed decode vectors, checked one cycle after acceptance.
      send(32'hFFF00093);
      check("addi_imm32", 64'(out_imm32), 64'hFFFF_FFFF);
      check("addi_fmt32", 64'(out_fmt32), 64'd0);
      check("addi_ill32", 64'(out_illegal32), 64'd0);
      check("addi_imm64", out_imm64, 64'hFFFF_FFFF_FFFF_FFFF);
      send(32'h00112623);
      check("sw_imm32", 64'(out_imm32), 64'h0000_000C);
      check("sw_fmt32", 64'(out_fmt32), 64'd1);
      send(32'hFE000EE3);
      check("beq_imm32", 64'(out_imm32), 64'hFFFF_FFFC);
      check("beq_fmt32", 64'(out_fmt32), 64'd2);
      send(32'h0010006F);
      check("jal_imm32", 64'(out_imm32), 64'h0000_0800);
      check("jal_fmt32", 64'(out_fmt32), 64'd4);
      send(32'h800002B7);
      check("lui_imm64", out_imm64, 64'hFFFF_FFFF_8000_0000);
      check("lui_fmt64", 64'(out_fmt64), 64'd3);
      check("lui_imm32", 64'(out_imm32), 64'h8000_0000);
      send(32'hFFF0009B);
      check("addiw_fmt64", 64'(out_fmt64), 64'd0);
      check("addiw_ill64", 64'(out_illegal64), 64'd0);
      check("addiw_fmt32", 64'(out_fmt32), 64'd7);
      check("addiw_ill32", 64'(out_illegal32), 64'd1);
      check("addiw_imm32", 64'(out_imm32), 64'd0);
      step();

      // Back-pressure on the skid instance: out_ready low for 3 cycles.
      out_ready = 1'b0;
      send(32'h00100093);
      in_valid = 1'b1;
      check("bp_rdy_one", 64'(in_ready32), 64'd1);
      in_instr = 32'h00200113;
      step();
      check("bp_rdy_drop", 64'(in_ready32), 64'd0);
      in_instr = 32'h00300193;
      step();
      check("bp_stable", 64'(out_instr32), 64'h0010_0093);
      out_ready = 1'b1;
      step();
      check("bp_promote", 64'(out_instr32), 64'h0020_0113);
      step();
      check("bp_third", 64'(out_instr32), 64'h0030_0193);
      in_instr = 32'h00400213;
      step();
      check("bp_fourth", 64'(out_instr32), 64'h0040_0213);
      in_valid = 1'b0;
      step();
      check("bp_empty", 64'(out_valid32), 64'd0);

      // Flush in state TWO with a pending input.
      out_ready = 1'b0;
      send(32'h00500293);
      in_valid = 1'b1;
      in_instr = 32'h00600313;
      step();
      in_instr = 32'h00700393;
      flush = 1'b1;
      step();
      check("flush_valid", 64'(out_valid32), 64'd0);
      flush = 1'b0;
      in_valid = 1'b0;
      out_ready = 1'b1;
      step();
      check("flush_gone", 64'(out_valid32), 64'd0);

      // Asynchronous reset in the middle of a stalled stream.
      out_ready = 1'b0;
      send(rand_instr());
      in_valid = 1'b1;
      in_instr = rand_instr();
      step();
      #2 reset = 1'b1;
      #1 check_reset_vals("arst");
      in_valid = 1'b0;
      step();
      reset = 1'b0;
      out_ready = 1'b1;

      // Counter saturation with a 2-bit counter.
      for (int k = 1; k <= 4; k++) begin
         send(32'hFFFF_FFFF);
         step();
         check("cnt_sat", 64'(illegal_cnt32), 64'((k > 3) ? 3 : k));
      end

      // Randomized traffic with flushes and back-pressure.
      for (int c = 0; c < 600; c++) begin
         in_valid  = ($urandom_range(0, 9) < 7);
         out_ready = ($urandom_range(0, 9) < 6);
         flush     = ($urandom_range(0, 15) == 0);
         in_instr  = rand_instr();
         in_pc     = {$urandom, $urandom};
         step();
      end
      flush = 1'b0;
      in_valid = 1'b0;
      out_ready = 1'b1;
      step();
      step();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
